ccx_trace_fifo: RTL and testbench

Instruction trace capture buffer downstream of the core top-level trace port. Each retired-instruction record (`trs_valid`/`trs_instr`/`trs_pc`) is captured into a DEPTH-entry FIFO. Records are drained as three 32-bit words over a valid/ready stream for a debug UART, DMA or BRAM logger. Overflow is counted, never back-pressured: the core trace port has no stall.

---
 rtl/ccx_trace_fifo.sv | 251 +++++++++++++++++++++++++
 tb/tb_ccx_trace_fifo.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccx_trace_fifo.sv
// Trace record capture FIFO: {pc, instr} entries drained as three 32-bit stream words.
// Define CCX_TRACE_GAP_MARK_EN to add per-entry drop-gap fields and a MARK word ahead of gapped records.
module ccx_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH)
) (
    input  logic        f_clk,
    input  logic        g_reset,
    input  logic        cap_en,
    input  logic        trs_valid,
    input  logic [31:0] trs_instr,
    input  logic [63:0] trs_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic [LW:0] level,
    output logic [15:0] ovf_count
);

`ifdef CCX_TRACE_GAP_MARK_EN
    localparam int EW = 112;
`else
    localparam int EW = 96;
`endif

    localparam logic [LW:0]   LVL_ZERO = '0;
    localparam logic [LW:0]   LVL_ONE  = (LW+1)'(1);
    localparam logic [LW:0]   LVL_FULL = (LW+1)'(DEPTH);
    localparam logic [LW-1:0] PTR_ZERO = '0;
    localparam logic [LW-1:0] PTR_ONE  = LW'(1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_W0   = 3'd1,
        ST_W1   = 3'd2,
`ifdef CCX_TRACE_GAP_MARK_EN
        ST_W2   = 3'd3,
        ST_MARK = 3'd4
`else
        ST_W2   = 3'd3
`endif
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [EW-1:0] mem_r [DEPTH];
    logic [LW-1:0] wr_ptr_r;
    logic [LW-1:0] rd_ptr_r;
    logic [LW-1:0] rd_ptr_nxt_s;
    logic [LW:0]   level_r;
    logic [15:0]   ovf_count_r;
    state_t        state_r;
    state_t        state_nxt_s;
    state_t        enter_s;
    logic          out_valid_r;
    logic [31:0]   out_data_r;
    logic          out_last_r;
    logic          out_valid_nxt_s;
    logic [31:0]   out_data_nxt_s;
    logic          out_last_nxt_s;
    logic [EW-1:0] entry_s;
    logic [EW-1:0] head_s;
    logic          full_s;
    logic          push_s;
    logic          drop_s;
    logic          hs_s;
    logic          pop_s;

    // Fullness uses the registered level, so a push coinciding with a pop at full is dropped.
    assign full_s = (level_r == LVL_FULL);
    assign push_s = trs_valid && cap_en && !full_s;
    assign drop_s = trs_valid && cap_en && full_s;
    assign hs_s   = out_valid_r && out_ready;
    assign pop_s  = hs_s && out_last_r;

`ifdef CCX_TRACE_GAP_MARK_EN
    logic [15:0] drop_run_r;

    // Drops since the last accepted push; snapshotted into the next entry's gap field.
    always_ff @(posedge f_clk) begin
        if (g_reset) begin
            drop_run_r <= 16'h0000;
        end else if (push_s) begin
            drop_run_r <= 16'h0000;
        end else if (drop_s) begin
            drop_run_r <= sat_inc16(drop_run_r);
        end else begin
            drop_run_r <= drop_run_r;
        end
    end

    assign entry_s = {drop_run_r, trs_pc, trs_instr};
`else
    assign entry_s = {trs_pc, trs_instr};
`endif

    // Entry storage; only the write port is clocked, reads are combinational off rd_ptr_nxt_s.
    always_ff @(posedge f_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    // Write pointer, read pointer, occupancy and overflow counter.
    always_ff @(posedge f_clk) begin
        if (g_reset) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            level_r     <= LVL_ZERO;
            ovf_count_r <= 16'h0000;
        end else begin
            wr_ptr_r <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            rd_ptr_r <= rd_ptr_nxt_s;
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
            ovf_count_r <= drop_s ? sat_inc16(ovf_count_r) : ovf_count_r;
        end
    end

    // Head pointer after this cycle's pop; the output registers load from the entry it selects.
    always_comb begin
        rd_ptr_nxt_s = rd_ptr_r;
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        head_s = mem_r[rd_ptr_nxt_s];
    end

    // First state of a record: MARK when the head carries a nonzero gap, else W0.
    always_comb begin
        enter_s = ST_W0;
`ifdef CCX_TRACE_GAP_MARK_EN
        if (head_s[111:96] != 16'h0000) begin
            enter_s = ST_MARK;
        end else begin
            enter_s = ST_W0;
        end
`endif
    end

    // Drain FSM next state: advance one word per handshake, hold while stalled.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (level_r != LVL_ZERO) begin
                    state_nxt_s = enter_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
`ifdef CCX_TRACE_GAP_MARK_EN
            ST_MARK: begin
                if (hs_s) begin
                    state_nxt_s = ST_W0;
                end else begin
                    state_nxt_s = ST_MARK;
                end
            end
`endif
            ST_W0: begin
                if (hs_s) begin
                    state_nxt_s = ST_W1;
                end else begin
                    state_nxt_s = ST_W0;
                end
            end
            ST_W1: begin
                if (hs_s) begin
                    state_nxt_s = ST_W2;
                end else begin
                    state_nxt_s = ST_W1;
                end
            end
            ST_W2: begin
                if (hs_s && (level_r > LVL_ONE)) begin
                    state_nxt_s = enter_s;
                end else if (hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_W2;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Stream outputs for the state being entered, so the ports come straight from flops.
    always_comb begin
        out_valid_nxt_s = 1'b0;
        out_data_nxt_s  = 32'h0000_0000;
        out_last_nxt_s  = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                out_valid_nxt_s = 1'b0;
            end
`ifdef CCX_TRACE_GAP_MARK_EN
            ST_MARK: begin
                out_valid_nxt_s = 1'b1;
                out_data_nxt_s  = {16'hC0DE, head_s[111:96]};
            end
`endif
            ST_W0: begin
                out_valid_nxt_s = 1'b1;
                out_data_nxt_s  = head_s[63:32];
            end
            ST_W1: begin
                out_valid_nxt_s = 1'b1;
                out_data_nxt_s  = head_s[95:64];
            end
            ST_W2: begin
                out_valid_nxt_s = 1'b1;
                out_data_nxt_s  = head_s[31:0];
                out_last_nxt_s  = 1'b1;
            end
            default: begin
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state and registered stream outputs; reset discards any partially sent record.
    always_ff @(posedge f_clk) begin
        if (g_reset) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            out_data_r  <= 32'h0000_0000;
            out_last_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_data_r  <= out_data_nxt_s;
            out_last_r  <= out_last_nxt_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign level     = level_r;
    assign ovf_count = ovf_count_r;

endmodule

// File: tb/tb_ccx_trace_fifo.sv
// Bench for ccx_trace_fifo: directed scenarios plus random traffic against a queue-based record model.
module tb_ccx_trace_fifo;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH);

    logic        f_clk = 1'b0;
    logic        g_reset;
    logic        cap_en;
    logic        trs_valid;
    logic [31:0] trs_instr;
    logic [63:0] trs_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic [LW:0] level;
    logic [15:0] ovf_count;

    ccx_trace_fifo #(.DEPTH(DEPTH)) dut (
        .f_clk     (f_clk),
        .g_reset   (g_reset),
        .cap_en    (cap_en),
        .trs_valid (trs_valid),
        .trs_instr (trs_instr),
        .trs_pc    (trs_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .level     (level),
        .ovf_count (ovf_count)
    );

    always #5 f_clk = ~f_clk;

    int checks   = 0;
    int failures = 0;

    // Model: queue of {gap, pc, instr} records, word index within the head, predicted out_valid.
    logic [111:0] mq[$];
    int           widx;
    logic         exp_valid;
    int           m_ovf;
    int           m_drop_run;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int n_words(input logic [111:0] r);
        return (r[111:96] != 16'h0000) ? 4 : 3;
    endfunction

    function automatic logic [31:0] word_at(input logic [111:0] r, input int idx);
        int k;
        k = idx - (n_words(r) - 3);
        if (k < 0) return {16'hC0DE, r[111:96]};
        else if (k == 0) return r[63:32];
        else if (k == 1) return r[95:64];
        else return r[31:0];
    endfunction

    task automatic rand_rec();
        trs_pc    = {$urandom, $urandom};
        trs_instr = $urandom;
    endtask

    // One clock: check current outputs, advance the model with current inputs, then check registers.
    task automatic tick();
        int           q_pre;
        logic         full_pre;
        logic         hs;
        logic         last_w;
        logic         nv;
        logic [111:0] rec;
        logic [15:0]  gap;
        q_pre    = mq.size();
        full_pre = (q_pre == DEPTH);
        hs       = exp_valid && out_ready;
        last_w   = 1'b0;
        if (exp_valid && q_pre > 0) begin
            rec    = mq[0];
            last_w = (widx == n_words(rec) - 1);
            check_val("out_data", 64'(out_data), 64'(word_at(rec, widx)));
            check_val("out_last", 64'(out_last), 64'(last_w));
        end
        if (!exp_valid) nv = (q_pre != 0);
        else if (hs && last_w) nv = (q_pre > 1);
        else nv = 1'b1;
        if (hs) begin
            if (last_w) begin
                void'(mq.pop_front());
                widx = 0;
            end else begin
                widx++;
            end
        end
        if (trs_valid && cap_en) begin
            if (full_pre) begin
                if (m_ovf < 65535) m_ovf++;
`ifdef CCX_TRACE_GAP_MARK_EN
                if (m_drop_run < 65535) m_drop_run++;
`endif
            end else begin
                gap = 16'(m_drop_run);
                mq.push_back({gap, trs_pc, trs_instr});
                m_drop_run = 0;
            end
        end
        @(posedge f_clk);
        #1;
        exp_valid = nv;
        check_val("out_valid", 64'(out_valid), 64'(exp_valid));
        check_val("level", 64'(level), 64'(mq.size()));
        check_val("ovf_count", 64'(ovf_count), 64'(m_ovf));
    endtask

    task automatic do_reset();
        g_reset   = 1'b1;
        trs_valid = 1'b0;
        @(posedge f_clk);
        #1;
        g_reset    = 1'b0;
        mq.delete();
        widx       = 0;
        exp_valid  = 1'b0;
        m_ovf      = 0;
        m_drop_run = 0;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_data", 64'(out_data), 64'd0);
        check_val("rst_out_last", 64'(out_last), 64'd0);
        check_val("rst_level", 64'(level), 64'd0);
        check_val("rst_ovf_count", 64'(ovf_count), 64'd0);
    endtask

    task automatic drain_all();
        trs_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (mq.size() == 0 && !exp_valid) break;
            tick();
        end
        check_val("drain_level", 64'(level), 64'd0);
        check_val("drain_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        g_reset   = 1'b1;
        cap_en    = 1'b1;
        trs_valid = 1'b0;
        trs_instr = 32'h0;
        trs_pc    = 64'h0;
        out_ready = 1'b0;
        do_reset();

        // Single record with ready high: valid two edges after the push, three words, level back to 0.
        out_ready = 1'b1;
        trs_valid = 1'b1;
        trs_pc    = 64'h0000_0001_8000_0040;
        trs_instr = 32'h0010_0093;
        tick();
        trs_valid = 1'b0;
        check_val("single_level_after_push", 64'(level), 64'd1);
        check_val("single_valid_after_push", 64'(out_valid), 64'd0);
        tick();
        check_val("single_w0", 64'(out_data), 64'h8000_0040);
        tick();
        check_val("single_w1", 64'(out_data), 64'h0000_0001);
        tick();
        check_val("single_w2", 64'(out_data), 64'h0010_0093);
        check_val("single_last", 64'(out_last), 64'd1);
        tick();
        check_val("single_level_end", 64'(level), 64'd0);
        tick();

        // Overflow: 20 pushes with the stream stalled, then drain the 16 survivors.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            trs_valid = 1'b1;
            rand_rec();
            tick();
        end
        trs_valid = 1'b0;
        check_val("ovf_fill_level", 64'(level), 64'd16);
        check_val("ovf_fill_count", 64'(ovf_count), 64'd4);
        drain_all();

        // Push at full on the cycle of a W2 handshake is dropped.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            trs_valid = 1'b1;
            rand_rec();
            tick();
        end
        trs_valid = 1'b0;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (out_valid && out_last) break;
            tick();
        end
        check_val("full_w2_reached", 64'(out_valid && out_last), 64'd1);
        trs_valid = 1'b1;
        rand_rec();
        tick();
        trs_valid = 1'b0;
        check_val("full_w2_level", 64'(level), 64'd15);
        check_val("full_w2_ovf", 64'(ovf_count), 64'd1);
        drain_all();

        // cap_en low: trace pulses neither push nor count.
        cap_en    = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            trs_valid = 1'b1;
            rand_rec();
            tick();
            trs_valid = 1'b0;
            tick();
        end
        check_val("capoff_level", 64'(level), 64'd0);
        check_val("capoff_ovf", 64'(ovf_count), 64'd1);
        cap_en = 1'b1;

        // Back-pressure: 4 records drained with out_ready toggling every cycle.
        for (int i = 0; i < 4; i++) begin
            trs_valid = 1'b1;
            rand_rec();
            tick();
        end
        trs_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            out_ready = (i % 2 == 0);
            tick();
        end
        drain_all();

        // Reset while in W1 discards the record; the next push streams from W0.
        out_ready = 1'b0;
        trs_valid = 1'b1;
        rand_rec();
        tick();
        trs_valid = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        check_val("mid_w1_valid", 64'(out_valid), 64'd1);
        do_reset();
        trs_valid = 1'b1;
        trs_pc    = 64'h1234_5678_9ABC_DEF0;
        trs_instr = 32'h0000_0013;
        tick();
        trs_valid = 1'b0;
        tick();
        check_val("post_rst_w0", 64'(out_data), 64'h9ABC_DEF0);
        drain_all();

        // Random traffic with varying push density, back-pressure and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            int p_push;
            int p_ready;
            p_push  = ((i / 300) % 3 == 0) ? 80 : (((i / 300) % 3 == 1) ? 30 : 10);
            p_ready = ((i / 500) % 2 == 0) ? 75 : 30;
            trs_valid = ($urandom_range(0, 99) < p_push);
            cap_en    = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 99) < p_ready);
            rand_rec();
            if ($urandom_range(0, 999) == 0) do_reset();
            else tick();
        end
        cap_en = 1'b0;
        drain_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
